// File: rtl/bus_arbiter.sv
// Two-port round-robin arbiter and bus sequencer: grants the CPU fetch or data port,
// decodes the address map into a one-hot slave strobe and returns done/err to the owner.
module bus_arbiter #(
    parameter logic [31:0] BOOT_SIZE      = 32'h0000_2000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req0,
    input  logic        i_req1,
    input  logic [31:0] i_addr0,
    input  logic [31:0] i_addr1,
    input  logic        i_we0,
    input  logic        i_we1,
    input  logic [3:0]  i_be0,
    input  logic [3:0]  i_be1,
    input  logic [31:0] i_wdata0,
    input  logic [31:0] i_wdata1,
    output logic        o_done0,
    output logic        o_done1,
    output logic        o_err0,
    output logic        o_err1,
    output logic [31:0] o_rdata,
    output logic        o_busy,
    output logic [7:0]  o_sel,
    output logic [31:0] o_addr,
    output logic [31:0] o_wdata,
    output logic        o_we,
    output logic [3:0]  o_be,
    input  logic        i_slave_done,
    input  logic [31:0] i_slave_rdata
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ERR} state_t;

    state_t            state, state_nxt;
    logic [1:0]        req;
    logic              win, owner, last;
    logic [31:0]       win_addr;
    logic [7:0]        sel_dec, sel_q;
    logic [CNT_W-1:0]  cnt;
    logic              timeout, err_q, resp;
    logic [31:0]       rdata_q;
    logic [1:0]        done_v, err_v;

    assign req      = {i_req1, i_req0};
    assign win      = (req == 2'b11) ? ~last : req[1];
    assign win_addr = win ? i_addr1 : i_addr0;
    assign timeout  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Bootloader window first, then one 256 MB region per slave up to 0x8000_0000.
    always_comb begin
        sel_dec = '0;
        if (win_addr < BOOT_SIZE)
            sel_dec[0] = 1'b1;
        else if (!win_addr[31] && win_addr[30:28] != 3'd0)
            sel_dec[win_addr[30:28]] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (|req) state_nxt = (sel_dec != '0) ? ISSUE : ERR;
            ISSUE:   state_nxt = i_slave_done ? RESP : WAIT;
            WAIT:    if (i_slave_done || timeout) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            owner   <= 1'b0;
            last    <= 1'b1;
            sel_q   <= '0;
            o_addr  <= '0;
            o_wdata <= '0;
            o_we    <= 1'b0;
            o_be    <= '0;
            cnt     <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (state == IDLE && |req) begin
                owner   <= win;
                last    <= win;
                sel_q   <= sel_dec;
                o_addr  <= win_addr;
                o_wdata <= win ? i_wdata1 : i_wdata0;
                o_we    <= win ? i_we1 : i_we0;
                o_be    <= win ? i_be1 : i_be0;
                cnt     <= '0;
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
            if (state == ISSUE || state == WAIT) begin
                cnt <= cnt + CNT_W'(1);
                // A done arriving in the timeout cycle still counts as success.
                if (i_slave_done) begin
                    rdata_q <= i_slave_rdata;
                end else if (state == WAIT && timeout) begin
                    err_q   <= 1'b1;
                    rdata_q <= '0;
                end
            end
        end
    end

    // Outputs decode from state so an asynchronous reset drops them at once.
    always_comb begin
        o_busy  = (state != IDLE);
        o_sel   = (state == ISSUE) ? sel_q : '0;
        o_rdata = (state == RESP) ? rdata_q : '0;
        resp    = (state == RESP) || (state == ERR);
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        assign done_v[p] = resp && (owner == 1'(p));
        assign err_v[p]  = done_v[p] && ((state == ERR) || err_q);
    end

    assign o_done0 = done_v[0];
    assign o_done1 = done_v[1];
    assign o_err0  = err_v[0];
    assign o_err1  = err_v[1];
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-requester arbiter and transaction sequencer that shares the single system memory bus between the CPU instruction-fetch port (requester 0) and data port (requester 1). It grants one requester at a time round-robin, decodes the granted address into a one-hot peripheral select using the system address map, and waits for the slave's completion. It returns a completion or error pulse to the owner, including on bus timeout. It sits between the core's two memory ports and the peripheral mux (bootloader ROM, SDRAM, GPU, PS/2, GPIO, HEX, test, SD card).

## Interface
- BOOT_SIZE, 32'h00002000, bootloader window size; address < BOOT_SIZE selects the bootloader
- TIMEOUT_CYCLES, 1024, maximum WAIT cycles before the transaction is aborted with error; must be ≥ 2
- i_clk  in  1  system clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_req0 / i_req1  in  1  request; held high with stable address and data until o_done of that port
- i_addr0 / i_addr1  in  32  byte address
- i_we0 / i_we1  in  1  1 = write
- i_be0 / i_be1  in  4  byte enables
- i_wdata0 / i_wdata1  in  32  write data
- o_done0 / o_done1  out  1  one-cycle completion pulse
- o_err0 / o_err1  out  1  pulses with o_done when the address is unmapped or the transaction timed out
- o_rdata  out  32  read data; valid only in the o_done cycle
- o_busy  out  1  high in every state except IDLE
- o_sel  out  8  one-hot slave strobe. Bit order: 0 bootloader, 1 sdram `[0x1000_0000, 0x2000_0000)`, 2 gpu, 3 ps2, 4 gpio, 5 hex, 6 test, 7 sd_card `[0x7000_0000, 0x8000_0000)`. Each 256 MB region after SDRAM follows in order.
- o_addr, o_wdata  out  32  registered copy of the granted request
- o_we  out  1, o_be  out  4  registered copy of the granted request
- i_slave_done  in  1  OR of all slave done/valid signals
- i_slave_rdata  in  32  muxed slave read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP, ERR.
- **IDLE:** if any request is present, choose a winner.
  - If only one port is requesting, that port wins.
  - If both are requesting, the port not served last wins.
  - Register the winner's address, we, be and wdata, plus the decoded select.
  - Mapped address: go to ISSUE. Unmapped address (in `[BOOT_SIZE, 0x1000_0000)` or ≥ 0x8000_0000): go to ERR.
  - Update last-served to the winner.
- **ISSUE:** o_sel is one-hot for exactly this cycle. Sample i_slave_done: if high, go to RESP; otherwise go to WAIT.
- **WAIT:** o_sel = 0 and o_addr/o_we/o_be/o_wdata are held.
  - Timeout counter increments each cycle.
  - i_slave_done: capture i_slave_rdata and go to RESP.
  - Counter reaches TIMEOUT_CYCLES−1 without done: set the error flag, force rdata to 0, go to RESP.
  - Done and timeout in the same cycle: done wins, no error.
- **RESP:** drive o_done and o_err of the owner for one cycle; o_rdata = captured data. Go to IDLE.
- **ERR:** drive o_done and o_err of the owner for one cycle; o_rdata = 0; no strobe is ever issued. Go to IDLE.
- i_slave_done in IDLE or RESP is ignored.
- Requester deasserts before done (protocol violation): the transaction still completes and the done pulse is still issued.
- Timeout counter width: clog2(TIMEOUT_CYCLES); cleared on entry to ISSUE.

## Timing
- Reset values (asynchronous on i_rst_n low):
  - state = IDLE; o_sel = 0; all done/err = 0; o_busy = 0
  - o_rdata, o_addr, o_wdata, o_be = 0; o_we = 0
  - last-served = 1, so port 0 wins the first tie
- Reset mid-transaction aborts immediately: no done pulse, o_sel drops asynchronously.
- Mapped latency, with a request sampled in IDLE at cycle 0:
  - o_sel at cycle 1
  - o_done at cycle k+1, where k (≥ 1) is the cycle i_slave_done is sampled high
  - IDLE at cycle k+2; the next grant is decided in that cycle
- Unmapped latency: o_done and o_err at cycle 1; IDLE at cycle 2.
- Timeout: o_done and o_err at cycle TIMEOUT_CYCLES+1.
- Throughput: at most one transaction per 3 cycles.
- Only the owner's o_done is ever asserted.

## Test plan
- Port 0 read of 0x0000_0010 while the slave asserts done with rdata 0xDEADBEEF in the ISSUE cycle → o_sel = 8'b0000_0001 at cycle 1, o_done0 with o_rdata = 0xDEADBEEF at cycle 2, o_err0 = 0.
- Port 0 and port 1 request continuously after reset, slave done 2 cycles after each strobe → grants alternate 0, 1, 0, 1; no port is served twice in a row.
- Port 1 write to 0x5000_0004, be = 4'b0011, wdata 0x1234 → o_sel bit 5 for one cycle with o_we = 1, o_be = 0011, o_wdata = 0x1234.
- Port 1 accesses 0x0800_0000, then 0x9000_0000 → each gives o_sel = 0, o_done1 and o_err1 one cycle after the request, o_rdata = 0.
- TIMEOUT_CYCLES = 8, slave never responds → o_done0 and o_err0 at cycle 9, o_rdata = 0. A second run with done exactly at the timeout cycle → no error.
- i_rst_n pulsed low in WAIT → all outputs 0 immediately, no done pulse. After release with both requesting, port 0 is granted first.
